// File: rtl/picorv_muldiv_pkg.sv
// Shared definitions for the PCPI multiply/divide sequencer.
//   - state_t: sequencer FSM states
//   - F3_*: RV M-extension funct3 operation codes
//   - OPC_OP / FUNCT7_MULDIV: fixed instruction fields identifying an M-extension op
//   - is_muldiv(): decode helper on a 32-bit instruction word
package picorv_muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/picorv_pcpi_muldiv_ctrl.sv
// Sequencer between the core PCPI port and the shared multiply/divide units.
// Accepts one M-extension instruction at a time, latches its operands, pulses
// the selected unit's start, waits (bounded by TIMEOUT) for that unit's ready
// and returns one registered write-back beat to the core.
//
// Optional build macro: PICORV_DIVZERO_FASTPATH_EN
//   When defined, a divide-class instruction with rs2 == 0 is answered directly
//   from IDLE (DIV/DIVU -> all-ones, REM/REMU -> rs1) without using the unit.
//
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   pcpi_valid/insn/rs1/rs2 request from the core
//   pcpi_ready              one-cycle completion beat
//   pcpi_wb_write/wb_data   write-back qualifier and result (0 unless ready)
//   unit_rs1/rs2/funct3     latched operands/op select to both units
//   mul_start/mul_ready/rd  multiply unit handshake
//   div_start/div_ready/rd  divide unit handshake
//   busy                    sequencer not idle
//   timeout_err             sticky, set when a unit fails to answer in time
module picorv_pcpi_muldiv_ctrl
  import picorv_muldiv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 256
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_ready,
  output logic            pcpi_wb_write,
  output logic [XLEN-1:0] pcpi_wb_data,
  output logic [XLEN-1:0] unit_rs1,
  output logic [XLEN-1:0] unit_rs2,
  output logic [2:0]      unit_funct3,
  output logic            mul_start,
  input  logic            mul_ready,
  input  logic [XLEN-1:0] mul_rd,
  output logic            div_start,
  input  logic            div_ready,
  input  logic [XLEN-1:0] div_rd,
  output logic            busy,
  output logic            timeout_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  state_t          state;
  logic [TW-1:0]   timer;
  // Set when the core withdrew pcpi_valid while the op was in flight; the
  // unit is still allowed to finish, but its result is thrown away.
  logic            flushed;

  logic            sel_ready;
  logic [XLEN-1:0] sel_rd;
  logic            resp_ok;

  // Register/rd fields are owned by the core; only opcode/funct3/funct7 matter.
  logic unused_insn;
  assign unused_insn = &{1'b0, pcpi_insn[24:15], pcpi_insn[11:7]};

  // Only the unit that was started may complete the op; the other unit's
  // ready is ignored even if it fires in the same cycle.
  assign sel_ready = unit_funct3[2] ? div_ready : mul_ready;
  assign sel_rd    = unit_funct3[2] ? div_rd    : mul_rd;
  assign resp_ok   = pcpi_valid && !flushed;

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      flushed       <= 1'b0;
      pcpi_ready    <= 1'b0;
      pcpi_wb_write <= 1'b0;
      pcpi_wb_data  <= '0;
      unit_rs1      <= '0;
      unit_rs2      <= '0;
      unit_funct3   <= '0;
      mul_start     <= 1'b0;
      div_start     <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      // Pulses and the response beat default low every cycle.
      mul_start     <= 1'b0;
      div_start     <= 1'b0;
      pcpi_ready    <= 1'b0;
      pcpi_wb_write <= 1'b0;
      pcpi_wb_data  <= '0;

      case (state)
        IDLE: begin
          if (pcpi_valid && is_muldiv(pcpi_insn)) begin
            unit_rs1    <= pcpi_rs1;
            unit_rs2    <= pcpi_rs2;
            unit_funct3 <= pcpi_insn[14:12];
            flushed     <= 1'b0;
`ifdef PICORV_DIVZERO_FASTPATH_EN
            if (pcpi_insn[14] && (pcpi_rs2 == '0)) begin
              // funct3[1] distinguishes REM/REMU from DIV/DIVU.
              pcpi_ready    <= 1'b1;
              pcpi_wb_write <= 1'b1;
              pcpi_wb_data  <= pcpi_insn[13] ? pcpi_rs1 : '1;
              state         <= RESP;
            end else begin
              mul_start <= !pcpi_insn[14];
              div_start <= pcpi_insn[14];
              state     <= ISSUE;
            end
`else
            mul_start <= !pcpi_insn[14];
            div_start <= pcpi_insn[14];
            state     <= ISSUE;
`endif
          end
        end

        ISSUE: begin
          // The start pulse is visible during this cycle.
          timer <= '0;
          if (!pcpi_valid) flushed <= 1'b1;
          state <= WAIT;
        end

        WAIT: begin
          if (timer != TIMER_MAX) timer <= timer + 1'b1;
          if (sel_ready) begin
            pcpi_ready    <= resp_ok;
            pcpi_wb_write <= resp_ok;
            pcpi_wb_data  <= resp_ok ? sel_rd : '0;
            state         <= RESP;
          end else if (timer == TIMER_LAST) begin
            // Error response: acknowledge without writing rd.
            pcpi_ready  <= resp_ok;
            timeout_err <= 1'b1;
            state       <= RESP;
          end else if (!pcpi_valid) begin
            flushed <= 1'b1;
          end
        end

        RESP: begin
          state <= DRAIN;
        end

        DRAIN: begin
          // Hold off until the core retires the request so the same
          // instruction is never dispatched twice.
          if (!pcpi_valid) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv_pcpi_muldiv_ctrl.sv
module tb_picorv_pcpi_muldiv_ctrl;
  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            pcpi_valid = 1'b0;
  logic [31:0]     pcpi_insn = '0;
  logic [XLEN-1:0] pcpi_rs1 = '0;
  logic [XLEN-1:0] pcpi_rs2 = '0;
  logic            pcpi_ready;
  logic            pcpi_wb_write;
  logic [XLEN-1:0] pcpi_wb_data;
  logic [XLEN-1:0] unit_rs1;
  logic [XLEN-1:0] unit_rs2;
  logic [2:0]      unit_funct3;
  logic            mul_start;
  logic            mul_ready = 1'b0;
  logic [XLEN-1:0] mul_rd = '0;
  logic            div_start;
  logic            div_ready = 1'b0;
  logic [XLEN-1:0] div_rd = '0;
  logic            busy;
  logic            timeout_err;

  picorv_pcpi_muldiv_ctrl #(.XLEN(XLEN), .TIMEOUT(256)) dut (
    .clock(clock), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_ready(pcpi_ready), .pcpi_wb_write(pcpi_wb_write),
    .pcpi_wb_data(pcpi_wb_data),
    .unit_rs1(unit_rs1), .unit_rs2(unit_rs2), .unit_funct3(unit_funct3),
    .mul_start(mul_start), .mul_ready(mul_ready), .mul_rd(mul_rd),
    .div_start(div_start), .div_ready(div_ready), .div_rd(div_rd),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0] data;
    logic            wb;
    int              lat;
  } exp_t;

  exp_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, resp_cnt = 0, mul_starts = 0, div_starts = 0;
  int mul_lat = 0, div_lat = 0, mul_cnt = 0, div_cnt = 0;
  logic [XLEN-1:0] mul_val = '0, div_val = '0;
  bit spur = 0;
  int n0, ms0, ds0;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample DUT after the edge, advance the unit models, and
  // score any response beat against the queue.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    mul_ready = 1'b0; mul_rd = '0;
    div_ready = 1'b0; div_rd = '0;
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin mul_ready = 1'b1; mul_rd = mul_val; end
    end
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        div_ready = 1'b1; div_rd = div_val;
        if (spur) begin mul_ready = 1'b1; mul_rd = XLEN'(99); end
      end
    end
    if (mul_start) begin mul_starts++; if (mul_lat > 0) mul_cnt = mul_lat; end
    if (div_start) begin div_starts++; if (div_lat > 0) div_cnt = div_lat; end
    if (!pcpi_ready) chk("data_zero_when_not_ready", pcpi_wb_data, '0);
    if (pcpi_ready) begin
      resp_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_ready observed=1 expected=0 cycle=%0d", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("resp cycle=%0d lat=%0d wb=%0b data=%0h", cyc, cyc - t0, pcpi_wb_write, pcpi_wb_data);
        chk("wb_data", pcpi_wb_data, e.data);
        chk("wb_write", XLEN'(pcpi_wb_write), XLEN'(e.wb));
        chk("latency", XLEN'(cyc - t0), XLEN'(e.lat));
      end
    end
  endtask

  task automatic send(input logic [2:0] f3, input logic [6:0] f7,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    pcpi_insn  = {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    pcpi_valid = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_resp(input int n, input int bound, input string tag);
    int k = 0;
    while (resp_cnt == n && k < bound) begin tick(); k++; end
    checks++;
    assert (resp_cnt != n) else begin
      errors++;
      $error("FAIL %s_no_response observed=none expected=ready within %0d", tag, bound);
    end
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int k = 0;
    while (busy && k < bound) begin tick(); k++; end
    chk({tag, "_idle"}, XLEN'(busy), '0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", XLEN'(pcpi_ready), '0);
    chk("rst_wb_write", XLEN'(pcpi_wb_write), '0);
    chk("rst_wb_data", pcpi_wb_data, '0);
    chk("rst_busy", XLEN'(busy), '0);
    chk("rst_timeout_err", XLEN'(timeout_err), '0);
    chk("rst_mul_start", XLEN'(mul_start), '0);
    chk("rst_div_start", XLEN'(div_start), '0);
    chk("rst_unit_rs1", unit_rs1, '0);
    #3 reset = 1'b0;
    tick();

    // MUL 7*6, unit answers 5 cycles after start
    n0 = resp_cnt; ms0 = mul_starts; ds0 = div_starts;
    mul_lat = 5; mul_val = XLEN'(42);
    send(3'b000, 7'b0000001, XLEN'(7), XLEN'(6));
    sb.push_back('{data: XLEN'(42), wb: 1'b1, lat: 7});
    tick();
    chk("mul_start_cycle1", XLEN'(mul_start), XLEN'(1));
    chk("mul_unit_rs1", unit_rs1, XLEN'(7));
    chk("mul_unit_rs2", unit_rs2, XLEN'(6));
    chk("mul_unit_funct3", XLEN'(unit_funct3), '0);
    chk("mul_busy", XLEN'(busy), XLEN'(1));
    wait_resp(n0, 20, "mul");
    pcpi_valid = 1'b0;
    wait_idle(5, "mul");
    chk("mul_start_count", XLEN'(mul_starts - ms0), XLEN'(1));
    chk("mul_no_div_start", XLEN'(div_starts - ds0), '0);

    // DIVU 100/7 with a spurious mul_ready in the same cycle
    n0 = resp_cnt; ms0 = mul_starts; ds0 = div_starts;
    div_lat = 4; div_val = XLEN'(14); spur = 1;
    send(3'b101, 7'b0000001, XLEN'(100), XLEN'(7));
    sb.push_back('{data: XLEN'(14), wb: 1'b1, lat: 6});
    wait_resp(n0, 20, "divu");
    repeat (3) tick();
    chk("divu_drain_busy", XLEN'(busy), XLEN'(1));
    chk("divu_single_start", XLEN'(div_starts - ds0), XLEN'(1));
    chk("divu_no_mul_start", XLEN'(mul_starts - ms0), '0);
    pcpi_valid = 1'b0;
    wait_idle(3, "divu");
    spur = 0;

    // Non-matching ADD held valid for 10 cycles
    n0 = resp_cnt; ms0 = mul_starts; ds0 = div_starts;
    send(3'b000, 7'b0000000, XLEN'(3), XLEN'(4));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("add_busy", XLEN'(busy), '0);
    end
    pcpi_valid = 1'b0;
    tick();
    chk("add_no_start", XLEN'((mul_starts - ms0) + (div_starts - ds0)), '0);
    chk("add_no_ready", XLEN'(resp_cnt - n0), '0);

    // Timeout: REM, divide unit never answers
    n0 = resp_cnt;
    div_lat = 0;
    send(3'b110, 7'b0000001, XLEN'(9), XLEN'(3));
    sb.push_back('{data: '0, wb: 1'b0, lat: 258});
    wait_resp(n0, 300, "timeout");
    chk("timeout_err_set", XLEN'(timeout_err), XLEN'(1));
    pcpi_valid = 1'b0;
    wait_idle(5, "timeout");
    chk("timeout_err_sticky", XLEN'(timeout_err), XLEN'(1));

    // Flush: valid drops two cycles into WAIT, unit answers later
    n0 = resp_cnt;
    mul_lat = 8; mul_val = XLEN'(5);
    send(3'b000, 7'b0000001, XLEN'(3), XLEN'(4));
    repeat (3) tick();
    pcpi_valid = 1'b0;
    repeat (12) tick();
    chk("flush_no_ready", XLEN'(resp_cnt - n0), '0);
    chk("flush_idle", XLEN'(busy), '0);

    // MULHU after flush is accepted normally
    n0 = resp_cnt;
    mul_lat = 2; mul_val = 64'h1234_5678_9abc_def0;
    send(3'b011, 7'b0000001, XLEN'(11), XLEN'(12));
    sb.push_back('{data: 64'h1234_5678_9abc_def0, wb: 1'b1, lat: 4});
    wait_resp(n0, 20, "mulhu");
    pcpi_valid = 1'b0;
    wait_idle(5, "mulhu");

    // Asynchronous reset in WAIT, asserted between clock edges
    div_lat = 0;
    send(3'b100, 7'b0000001, XLEN'(100), XLEN'(3));
    repeat (3) tick();
    chk("pre_reset_busy", XLEN'(busy), XLEN'(1));
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", XLEN'(busy), '0);
    chk("arst_ready", XLEN'(pcpi_ready), '0);
    chk("arst_wb_write", XLEN'(pcpi_wb_write), '0);
    chk("arst_wb_data", pcpi_wb_data, '0);
    chk("arst_div_start", XLEN'(div_start), '0);
    chk("arst_unit_rs1", unit_rs1, '0);
    chk("arst_unit_rs2", unit_rs2, '0);
    chk("arst_timeout_err", XLEN'(timeout_err), '0);
    pcpi_valid = 1'b0;
    mul_cnt = 0; div_cnt = 0;
    tick();
    #3 reset = 1'b0;
    tick();

    // DIV by zero after reset
    n0 = resp_cnt; ds0 = div_starts;
`ifdef PICORV_DIVZERO_FASTPATH_EN
    send(3'b100, 7'b0000001, XLEN'(77), '0);
    sb.push_back('{data: '1, wb: 1'b1, lat: 1});
    wait_resp(n0, 10, "div0");
    pcpi_valid = 1'b0;
    wait_idle(5, "div0");
    chk("div0_no_start", XLEN'(div_starts - ds0), '0);
    n0 = resp_cnt;
    send(3'b110, 7'b0000001, XLEN'(77), '0);
    sb.push_back('{data: XLEN'(77), wb: 1'b1, lat: 1});
    wait_resp(n0, 10, "rem0");
    pcpi_valid = 1'b0;
    wait_idle(5, "rem0");
`else
    div_lat = 3; div_val = '1;
    send(3'b100, 7'b0000001, XLEN'(77), '0);
    sb.push_back('{data: '1, wb: 1'b1, lat: 5});
    wait_resp(n0, 20, "div0");
    pcpi_valid = 1'b0;
    wait_idle(5, "div0");
    chk("div0_via_unit", XLEN'(div_starts - ds0), XLEN'(1));
`endif

    chk("scoreboard_empty", XLEN'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
